cpu_bus_arbiter: RTL and testbench
==================================

Name: cpu_bus_arbiter

Overview:
Sits between the cpu core and the shared system bus (RAM, PPU, APU/IO, cartridge). It forwards CPU read/write strobes as held bus transactions and returns read data to the CPU. It also owns the OAM DMA engine: a CPU write to the DMA register stalls the CPU and copies 256 bytes from page P to the OAM data port, sharing the bus between the two requesters.

Parameters:
DMA_REGISTER_ADDRESS, 16'h4014, CPU write address that triggers DMA; this write is never forwarded to the bus.
DMA_TARGET_ADDRESS, 16'h2004, bus address every DMA byte is written to.
DMA_LENGTH, 256, bytes per DMA; range 1..256; source offsets 0..DMA_LENGTH-1.

Ports:
clock_i  in  1  system clock.
reset_i  in  1  asynchronous, active-high reset.
cpu_address_i  in  16  CPU request address; sampled when cpu_address_valid_i=1.
cpu_address_valid_i  in  1  one-cycle CPU request strobe.
cpu_data_i  in  8  CPU write data.
cpu_data_valid_i  in  1  with cpu_address_valid_i: request is a write; otherwise a read.
cpu_data_o  out  8  read data returned to CPU.
cpu_data_valid_o  out  1  one-cycle read-completion strobe.
cpu_stall_o  out  1  CPU must not issue new requests while high (RDY).
bus_request_o  out  1  transaction request; held until accepted.
bus_write_o  out  1  1=write, 0=read; stable while bus_request_o=1.
bus_address_o  out  16  transaction address.
bus_data_o  out  8  write data.
bus_ready_i  in  1  target accepts/completes in the cycle bus_request_o & bus_ready_i.
bus_data_i  in  8  read data; valid in the accept cycle of a read.

Behaviour:
- Reset, async: all outputs 0; state IDLE; pending buffer empty; DMA counter 0. Mid-transaction reset aborts and drops pending and DMA state. bus_request_o falls immediately.
- Pending buffer:
  - One entry.
  - A CPU strobe always loads it (address, data, write flag).
  - A strobe arriving while the entry is full is a protocol violation; the new request overwrites the old one. Benches flag it.
- States: IDLE, CPU_ACCESS, DMA_READ, DMA_WRITE.
- IDLE with pending entry:
  - Write to DMA_REGISTER_ADDRESS: latch page P = data; clear the entry; counter 0; cpu_stall_o=1 next cycle; go to DMA_READ.
  - Any other request: drive bus_* from the entry next cycle; go to CPU_ACCESS.
- CPU_ACCESS:
  - Hold bus_* until bus_ready_i.
  - On accept: drop bus_request_o next cycle, clear the entry, return to IDLE.
  - Read: cpu_data_o <= bus_data_i and cpu_data_valid_o=1 for exactly one cycle, the cycle after accept. cpu_data_o holds its value afterwards.
  - Write: no CPU response.
- Latency: a read strobe in cycle N with bus_ready_i tied 1 gives bus_request_o in N+1 and cpu_data_valid_o in N+2. A write likewise occupies the bus in N+1.
- DMA_READ:
  - Read address = {P, counter[7:0]}.
  - On accept: latch byte; go to DMA_WRITE.
- DMA_WRITE:
  - Write latched byte to DMA_TARGET_ADDRESS.
  - On accept: if counter == DMA_LENGTH-1, go to IDLE and clear cpu_stall_o the next cycle; else counter+1 and go to DMA_READ.
  - Counter is 9 bits; no wrap into page P+1.
- Every state transition is one idle bus cycle; bus_request_o drops for one cycle between transactions.
- Bus sharing, priority DMA > CPU:
  - A CPU strobe landing in the same cycle the DMA write is accepted, or during DMA, stays pending.
  - It is serviced from IDLE after DMA completes.
  - cpu_data_valid_o never pulses during DMA.
- A second DMA-register write in the pending entry after a DMA starts a fresh DMA on return to IDLE.
- bus_ready_i asserted without bus_request_o is ignored.

Decomposition:
- Package bus_pkg:
  - arbiter_state_t enum (IDLE, CPU_ACCESS, DMA_READ, DMA_WRITE).
  - bus_request_t packed struct {address[15:0], data[7:0], write}.
  - Default constants for DMA_REGISTER_ADDRESS and DMA_TARGET_ADDRESS.
- Sub-module oam_dma_engine:
  - Holds page, counter and byte latch.
  - Exposes start, the current bus_request_t, accept and done.
  - The arbiter keeps the FSM, pending buffer and CPU response path.

Test Plan:
- Read: strobe addr 16'h0123, ready tied 1, bus_data_i=8'hA5 -> bus read of 16'h0123 in N+1; cpu_data_o=8'hA5 with one-cycle valid in N+2.
- Write with wait states: write 8'h3C to 16'h2006, ready held low 3 cycles -> request/address/data stable for 4 cycles; single accept; no cpu_data_valid_o.
- DMA: write 8'h02 to 16'h4014; memory[16'h0200+i]=i^8'hFF -> no bus write to 16'h4014; 256 alternating reads 16'h0200..16'h02FF and writes to 16'h2004 carrying i^8'hFF; cpu_stall_o high throughout; low after the final write.
- Pending during DMA: read strobe of 16'h0010 mid-DMA -> held; serviced only after the last DMA write; exactly one cpu_data_valid_o.
- Reset mid-DMA at byte 17 -> outputs 0 immediately; the next CPU read of 16'h0000 executes normally.
- DMA_LENGTH=4 instance, page 8'hFF -> reads 16'hFF00..16'hFF03 only; no access to 16'h0000.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and default constants for the CPU bus arbiter and its OAM DMA
// engine.
//   arbiter_state_t : arbiter FSM states
//   bus_request_t   : one bus transaction (address, write data, write flag)
//   is_dma_trigger  : true when a request is a write to the DMA register
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACCESS,
        DMA_READ,
        DMA_WRITE
    } arbiter_state_t;

    typedef struct packed {
        logic [15:0] address;
        logic [7:0]  data;
        logic        write;
    } bus_request_t;

    localparam logic [15:0] DEFAULT_DMA_REGISTER_ADDRESS = 16'h4014;
    localparam logic [15:0] DEFAULT_DMA_TARGET_ADDRESS   = 16'h2004;
    localparam int          DEFAULT_DMA_LENGTH           = 256;

    function automatic logic is_dma_trigger(input bus_request_t req,
                                            input logic [15:0]  reg_address);
        return req.write && (req.address == reg_address);
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// -----------------------------------------------------------------------------
// oam_dma_engine
// Datapath of the OAM DMA: source page, 9-bit byte counter and the byte latch
// carried from each read to the following write. The arbiter FSM sequences it.
// Ports:
//   clock_i, reset_i   clock, async active-high reset
//   start_i, page_i    begin a fresh DMA from page page_i (counter -> 0)
//   write_phase_i      1 while the arbiter is in the DMA write state
//   accept_i           current DMA bus transaction accepted this cycle
//   bus_data_i         read data, latched on an accepted read
//   request_o          bus transaction for the current phase
//   done_o             counter sits on the last byte index
// -----------------------------------------------------------------------------
module oam_dma_engine
    import bus_pkg::*;
#(
    parameter logic [15:0] DMA_TARGET_ADDRESS = DEFAULT_DMA_TARGET_ADDRESS,
    parameter int          DMA_LENGTH         = DEFAULT_DMA_LENGTH
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [7:0]   page_i,
    input  logic         write_phase_i,
    input  logic         accept_i,
    input  logic [7:0]   bus_data_i,
    output bus_request_t request_o,
    output logic         done_o
);

    localparam logic [8:0] LAST_INDEX = 9'(DMA_LENGTH - 1);

    logic [7:0] page_q,  page_d;
    logic [8:0] count_q, count_d;
    logic [7:0] byte_q,  byte_d;

    assign done_o = (count_q == LAST_INDEX);

    always_comb begin
        page_d  = page_q;
        count_d = count_q;
        byte_d  = byte_q;
        if (start_i) begin
            page_d  = page_i;
            count_d = '0;
        end else if (accept_i) begin
            if (write_phase_i) begin
                // Counter stops on the last index; it never rolls into page+1.
                if (!done_o) begin
                    count_d = count_q + 9'd1;
                end
            end else begin
                byte_d = bus_data_i;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            page_q  <= '0;
            count_q <= '0;
            byte_q  <= '0;
        end else begin
            page_q  <= page_d;
            count_q <= count_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        if (write_phase_i) begin
            request_o.address = DMA_TARGET_ADDRESS;
            request_o.data    = byte_q;
            request_o.write   = 1'b1;
        end else begin
            request_o.address = {page_q, count_q[7:0]};
            request_o.data    = 8'h00;
            request_o.write   = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
// Forwards CPU strobes as held bus transactions, returns read data, and runs
// OAM DMA (DMA has priority over the CPU) when the DMA register is written.
// Ports:
//   clock_i, reset_i                     clock, async active-high reset
//   cpu_address_i/_valid_i, cpu_data_i/_valid_i   CPU request strobe (write
//                                         when cpu_data_valid_i is also high)
//   cpu_data_o, cpu_data_valid_o          read data and one-cycle completion
//   cpu_stall_o                           CPU must hold off (DMA running)
//   bus_request_o/_write_o/_address_o/_data_o     held bus transaction
//   bus_ready_i, bus_data_i               accept strobe and read data
// -----------------------------------------------------------------------------
module cpu_bus_arbiter
    import bus_pkg::*;
#(
    parameter logic [15:0] DMA_REGISTER_ADDRESS = DEFAULT_DMA_REGISTER_ADDRESS,
    parameter logic [15:0] DMA_TARGET_ADDRESS   = DEFAULT_DMA_TARGET_ADDRESS,
    parameter int          DMA_LENGTH           = DEFAULT_DMA_LENGTH
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_data_valid_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic        cpu_stall_o,
    output logic        bus_request_o,
    output logic        bus_write_o,
    output logic [15:0] bus_address_o,
    output logic [7:0]  bus_data_o,
    input  logic        bus_ready_i,
    input  logic [7:0]  bus_data_i
);

    arbiter_state_t state_q, state_d;
    logic           req_q, req_d;
    logic           stall_q, stall_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           rvalid_q, rvalid_d;
    bus_request_t   entry_q, entry_d;
    logic           entry_valid_q, entry_valid_d;
    bus_request_t   cpu_req_q, cpu_req_d;

    bus_request_t   strobe_req;
    bus_request_t   effective_req;
    bus_request_t   dma_request;
    bus_request_t   bus_view;
    logic           accept;
    logic           dma_start;
    logic           dma_accept;
    logic           dma_write_phase;
    logic           dma_done;

    assign accept          = req_q & bus_ready_i;
    assign dma_write_phase = (state_q == DMA_WRITE);

    always_comb begin
        strobe_req.address = cpu_address_i;
        strobe_req.data    = cpu_data_i;
        strobe_req.write   = cpu_data_valid_i;
        // A strobe in the same cycle as a full entry overwrites it, so the
        // strobe wins when choosing what IDLE launches.
        effective_req      = cpu_address_valid_i ? strobe_req : entry_q;
    end

    oam_dma_engine #(
        .DMA_TARGET_ADDRESS (DMA_TARGET_ADDRESS),
        .DMA_LENGTH         (DMA_LENGTH)
    ) u_dma (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .start_i       (dma_start),
        .page_i        (effective_req.data),
        .write_phase_i (dma_write_phase),
        .accept_i      (dma_accept),
        .bus_data_i    (bus_data_i),
        .request_o     (dma_request),
        .done_o        (dma_done)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        stall_d       = stall_q;
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        entry_d       = entry_q;
        entry_valid_d = entry_valid_q;
        cpu_req_d     = cpu_req_q;
        dma_start     = 1'b0;
        dma_accept    = 1'b0;

        if (cpu_address_valid_i) begin
            entry_d       = strobe_req;
            entry_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cpu_address_valid_i || entry_valid_q) begin
                    req_d = 1'b1;
                    if (is_dma_trigger(effective_req, DMA_REGISTER_ADDRESS)) begin
                        dma_start     = 1'b1;
                        entry_valid_d = 1'b0;
                        stall_d       = 1'b1;
                        state_d       = DMA_READ;
                    end else begin
                        cpu_req_d = effective_req;
                        state_d   = CPU_ACCESS;
                    end
                end
            end
            CPU_ACCESS: begin
                if (accept) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!cpu_address_valid_i) begin
                        entry_valid_d = 1'b0;
                    end
                    if (!cpu_req_q.write) begin
                        rdata_d  = bus_data_i;
                        rvalid_d = 1'b1;
                    end
                end
            end
            DMA_READ: begin
                // Request is low for exactly one cycle after each accept.
                if (accept) begin
                    dma_accept = 1'b1;
                    req_d      = 1'b0;
                    state_d    = DMA_WRITE;
                end else begin
                    req_d = 1'b1;
                end
            end
            DMA_WRITE: begin
                if (accept) begin
                    dma_accept = 1'b1;
                    req_d      = 1'b0;
                    if (dma_done) begin
                        stall_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DMA_READ;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            stall_q       <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            entry_q       <= '0;
            entry_valid_q <= 1'b0;
            cpu_req_q     <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            stall_q       <= stall_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            entry_q       <= entry_d;
            entry_valid_q <= entry_valid_d;
            cpu_req_q     <= cpu_req_d;
        end
    end

    // Bus fields come straight from the state so a reset clears them at once.
    always_comb begin
        bus_view = '0;
        case (state_q)
            CPU_ACCESS:          bus_view = cpu_req_q;
            DMA_READ, DMA_WRITE: bus_view = dma_request;
            default:             bus_view = '0;
        endcase
    end

    assign bus_request_o    = req_q;
    assign bus_write_o      = bus_view.write;
    assign bus_address_o    = bus_view.address;
    assign bus_data_o       = bus_view.data;
    assign cpu_data_o       = rdata_q;
    assign cpu_data_valid_o = rvalid_q;
    assign cpu_stall_o      = stall_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
    } txn_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic [7:0]  memval;
        int          waits;
        logic        exp_valid;
        logic [7:0]  exp_cpu_data;
    } vec_t;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    logic [15:0] cpu_address_i = '0;
    logic        cpu_address_valid_i = 1'b0;
    logic [7:0]  cpu_data_i = '0;
    logic        cpu_data_valid_i = 1'b0;
    logic [7:0]  cpu_data_o;
    logic        cpu_data_valid_o;
    logic        cpu_stall_o;
    logic        bus_request_o;
    logic        bus_write_o;
    logic [15:0] bus_address_o;
    logic [7:0]  bus_data_o;
    logic        bus_ready_i = 1'b0;
    logic [7:0]  bus_data_i = '0;

    logic [15:0] cpu_address_i2 = '0;
    logic        cpu_address_valid_i2 = 1'b0;
    logic [7:0]  cpu_data_i2 = '0;
    logic        cpu_data_valid_i2 = 1'b0;
    logic [7:0]  cpu_data_o2;
    logic        cpu_data_valid_o2;
    logic        cpu_stall_o2;
    logic        bus_request_o2;
    logic        bus_write_o2;
    logic [15:0] bus_address_o2;
    logic [7:0]  bus_data_o2;
    logic        bus_ready_i2 = 1'b1;
    logic [7:0]  bus_data_i2 = '0;

    cpu_bus_arbiter dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .cpu_address_i(cpu_address_i), .cpu_address_valid_i(cpu_address_valid_i),
        .cpu_data_i(cpu_data_i), .cpu_data_valid_i(cpu_data_valid_i),
        .cpu_data_o(cpu_data_o), .cpu_data_valid_o(cpu_data_valid_o),
        .cpu_stall_o(cpu_stall_o), .bus_request_o(bus_request_o),
        .bus_write_o(bus_write_o), .bus_address_o(bus_address_o),
        .bus_data_o(bus_data_o), .bus_ready_i(bus_ready_i), .bus_data_i(bus_data_i)
    );

    cpu_bus_arbiter #(.DMA_LENGTH(4)) dut2 (
        .clock_i(clock_i), .reset_i(reset_i),
        .cpu_address_i(cpu_address_i2), .cpu_address_valid_i(cpu_address_valid_i2),
        .cpu_data_i(cpu_data_i2), .cpu_data_valid_i(cpu_data_valid_i2),
        .cpu_data_o(cpu_data_o2), .cpu_data_valid_o(cpu_data_valid_o2),
        .cpu_stall_o(cpu_stall_o2), .bus_request_o(bus_request_o2),
        .bus_write_o(bus_write_o2), .bus_address_o(bus_address_o2),
        .bus_data_o(bus_data_o2), .bus_ready_i(bus_ready_i2), .bus_data_i(bus_data_i2)
    );

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    txn_t       log1[$];
    txn_t       log2[$];
    logic [7:0] resp1[$];
    int         checks = 0;
    int         failures = 0;
    int         mode = 0;       // 0: ready tied 1, 1: random ready, 2: scripted waits
    int         wait_left = 0;

    logic        rdy1;
    logic        hold_pending = 1'b0;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;
    logic        hold_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bus target for the main instance plus protocol monitors.
    always @(negedge clock_i) begin
        if (mode == 0) rdy1 = 1'b1;
        else if (mode == 1) rdy1 = ($urandom_range(0, 2) != 0);
        else if (bus_request_o && wait_left > 0) begin
            rdy1 = 1'b0;
            wait_left--;
        end else rdy1 = 1'b1;

        if (hold_pending && !reset_i) begin
            chk("hold_request", bus_request_o, 1);
            chk("hold_fields", {bus_address_o, bus_data_o, bus_write_o},
                {hold_addr, hold_data, hold_wr});
        end
        hold_pending = bus_request_o && !rdy1;
        hold_addr    = bus_address_o;
        hold_data    = bus_data_o;
        hold_wr      = bus_write_o;

        bus_ready_i = rdy1;
        bus_data_i  = mem[bus_address_o];
        if (bus_request_o && rdy1) begin
            log1.push_back('{bus_address_o, bus_write_o, bus_data_o});
            if (bus_write_o) begin
                mem[bus_address_o] = bus_data_o;
                chk("dma_reg_not_forwarded", {31'b0, bus_address_o == 16'h4014}, 0);
            end
        end
        if (cpu_data_valid_o) begin
            resp1.push_back(cpu_data_o);
            chk("valid_outside_dma", cpu_stall_o, 0);
        end
    end

    always @(negedge clock_i) begin
        bus_data_i2 = mem[bus_address_o2];
        if (bus_request_o2 && bus_ready_i2) begin
            log2.push_back('{bus_address_o2, bus_write_o2, bus_data_o2});
            if (bus_write_o2) mem[bus_address_o2] = bus_data_o2;
        end
    end

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic wr);
        @(negedge clock_i);
        cpu_address_i       = a;
        cpu_data_i          = d;
        cpu_data_valid_i    = wr;
        cpu_address_valid_i = 1'b1;
        @(negedge clock_i);
        cpu_address_valid_i = 1'b0;
        cpu_data_valid_i    = 1'b0;
    endtask

    task automatic wait_stall_low(output int cycles);
        cycles = 0;
        while (cpu_stall_o && cycles < 5000) begin
            cycles++;
            @(negedge clock_i);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req"},   bus_request_o, 0);
        chk({tag, "_stall"}, cpu_stall_o, 0);
        chk({tag, "_valid"}, cpu_data_valid_o, 0);
        chk({tag, "_bus"},   {bus_address_o, bus_data_o, bus_write_o}, 0);
        chk({tag, "_rdata"}, cpu_data_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    txn_t exp_txn[$];
    logic [7:0] exp_resp[$];

    initial begin
        int n, base, tcmp, rcmp, dmas;
        logic [15:0] a;
        logic [7:0] d, pg;

        vecs[0] = '{16'h0123, 8'h00, 1'b0, 8'hA5, 0, 1'b1, 8'hA5};
        vecs[1] = '{16'h2006, 8'h3C, 1'b1, 8'h00, 3, 1'b0, 8'hA5};
        vecs[2] = '{16'hFFFF, 8'h00, 1'b0, 8'h5A, 2, 1'b1, 8'h5A};
        vecs[3] = '{16'h0000, 8'h00, 1'b1, 8'h11, 0, 1'b0, 8'h5A};
        vecs[4] = '{16'h4014, 8'h00, 1'b0, 8'h77, 1, 1'b1, 8'h77};
        vecs[5] = '{16'h4015, 8'h81, 1'b1, 8'h00, 0, 1'b0, 8'h77};
        vecs[6] = '{16'h2004, 8'h00, 1'b0, 8'hC3, 4, 1'b1, 8'hC3};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset state, then idle ready must be ignored.
        repeat (3) @(negedge clock_i);
        chk_outputs_zero("reset");
        reset_i = 1'b0;
        repeat (4) @(negedge clock_i);
        chk("ready_without_request", log1.size(), 0);
        chk("idle_no_valid", resp1.size(), 0);

        // Single transactions with scripted wait states.
        mode = 2;
        for (int i = 0; i < 7; i++) begin
            wait_left = vecs[i].waits;
            mem[vecs[i].addr] = vecs[i].memval;
            base = log1.size();
            strobe(vecs[i].addr, vecs[i].wdata, vecs[i].wr);
            chk($sformatf("v%0d_req_n1", i), bus_request_o, 1);
            chk($sformatf("v%0d_addr", i), bus_address_o, vecs[i].addr);
            chk($sformatf("v%0d_write", i), bus_write_o, vecs[i].wr);
            if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), bus_data_o, vecs[i].wdata);
            for (int k = 0; k < vecs[i].waits; k++) begin
                @(negedge clock_i);
                chk($sformatf("v%0d_hold_req", i), bus_request_o, 1);
                chk($sformatf("v%0d_hold_addr", i), bus_address_o, vecs[i].addr);
            end
            @(negedge clock_i);
            chk($sformatf("v%0d_req_drop", i), bus_request_o, 0);
            chk($sformatf("v%0d_valid", i), cpu_data_valid_o, vecs[i].exp_valid);
            chk($sformatf("v%0d_rdata", i), cpu_data_o, vecs[i].exp_cpu_data);
            @(negedge clock_i);
            chk($sformatf("v%0d_valid_one", i), cpu_data_valid_o, 0);
            chk($sformatf("v%0d_accepts", i), log1.size() - base, 1);
            chk($sformatf("v%0d_stall", i), cpu_stall_o, 0);
        end

        // Full DMA from page 0x02.
        mode = 0;
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hFF;
        log1.delete();
        resp1.delete();
        strobe(16'h4014, 8'h02, 1'b1);
        chk("dma_stall_n1", cpu_stall_o, 1);
        chk("dma_req_n1", bus_request_o, 1);
        chk("dma_first_addr", bus_address_o, 16'h0200);
        wait_stall_low(n);
        chk("dma_stall_cycles", n, 1023);
        chk("dma_req_after", bus_request_o, 0);
        chk("dma_txn_count", log1.size(), 512);
        if (log1.size() >= 512) begin
            for (int i = 0; i < 256; i++) begin
                chk($sformatf("dma_rd%0d", i), {log1[2*i].addr, log1[2*i].wr},
                    {16'h0200 + 16'(i), 1'b0});
                chk($sformatf("dma_wr%0d", i),
                    {log1[2*i+1].addr, log1[2*i+1].wr, log1[2*i+1].data},
                    {16'h2004, 1'b1, 8'(i) ^ 8'hFF});
            end
        end

        // CPU read issued mid-DMA stays pending until the DMA finishes.
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i + 3);
        mem[16'h0010] = 8'h99;
        log1.delete();
        resp1.delete();
        strobe(16'h4014, 8'h03, 1'b1);
        repeat (100) @(negedge clock_i);
        strobe(16'h0010, 8'h00, 1'b0);
        wait_stall_low(n);
        chk("pend_no_resp_during_dma", resp1.size(), 0);
        chk("pend_req_gap", bus_request_o, 0);
        @(negedge clock_i);
        chk("pend_req", bus_request_o, 1);
        chk("pend_addr", {bus_address_o, bus_write_o}, {16'h0010, 1'b0});
        @(negedge clock_i);
        chk("pend_valid", cpu_data_valid_o, 1);
        chk("pend_rdata", cpu_data_o, 8'h99);
        @(negedge clock_i);
        chk("pend_valid_one", cpu_data_valid_o, 0);
        chk("pend_resp_count", resp1.size(), 1);
        chk("pend_txn_count", log1.size(), 513);
        if (log1.size() >= 513) begin
            chk("pend_last_dma_wr", {log1[511].addr, log1[511].data}, {16'h2004, 8'h02});
            chk("pend_after_dma", log1[512].addr, 16'h0010);
        end

        // Reset while DMA is on byte 17.
        strobe(16'h4014, 8'h05, 1'b1);
        n = 0;
        while (!(bus_request_o && bus_address_o == 16'h0511) && n < 1000) begin
            n++;
            @(negedge clock_i);
        end
        chk("rst_reached_byte17", {31'b0, n < 1000}, 1);
        reset_i = 1'b1;
        #1;
        chk_outputs_zero("rst_mid_dma");
        @(negedge clock_i);
        reset_i = 1'b0;
        mem[16'h0000] = 8'h42;
        log1.delete();
        resp1.delete();
        strobe(16'h0000, 8'h00, 1'b0);
        chk("post_rst_req", bus_request_o, 1);
        chk("post_rst_addr", {bus_address_o, bus_write_o}, {16'h0000, 1'b0});
        chk("post_rst_stall", cpu_stall_o, 0);
        @(negedge clock_i);
        chk("post_rst_valid", cpu_data_valid_o, 1);
        chk("post_rst_rdata", cpu_data_o, 8'h42);
        @(negedge clock_i);
        chk("post_rst_txn_count", log1.size(), 1);

        // Four-byte DMA instance from the top page.
        for (int i = 0; i < 4; i++) mem[16'hFF00 + i] = 8'(8'h10 + i);
        log2.delete();
        @(negedge clock_i);
        cpu_address_i2 = 16'h4014; cpu_data_i2 = 8'hFF;
        cpu_data_valid_i2 = 1'b1; cpu_address_valid_i2 = 1'b1;
        @(negedge clock_i);
        cpu_address_valid_i2 = 1'b0; cpu_data_valid_i2 = 1'b0;
        chk("len4_stall", cpu_stall_o2, 1);
        n = 0;
        while (cpu_stall_o2 && n < 200) begin
            n++;
            @(negedge clock_i);
        end
        chk("len4_stall_cycles", n, 15);
        repeat (3) @(negedge clock_i);
        chk("len4_txn_count", log2.size(), 8);
        if (log2.size() >= 8) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("len4_rd%0d", i), {log2[2*i].addr, log2[2*i].wr},
                    {16'hFF00 + 16'(i), 1'b0});
                chk($sformatf("len4_wr%0d", i),
                    {log2[2*i+1].addr, log2[2*i+1].wr, log2[2*i+1].data},
                    {16'h2004, 1'b1, 8'(8'h10 + i)});
            end
        end
        n = 0;
        foreach (log2[k]) if (log2[k].addr == 16'h0000) n++;
        chk("len4_no_page_wrap", n, 0);

        // Randomized traffic against an in-order transaction model.
        mode = 1;
        for (int i = 0; i < 65536; i++) begin
            d = 8'($urandom);
            mem[i] = d;
            ref_mem[i] = d;
        end
        log1.delete();
        resp1.delete();
        tcmp = 0;
        rcmp = 0;
        dmas = 0;
        for (int op = 0; op < 40; op++) begin
            n = $urandom_range(0, 99);
            if (n < 8 && dmas < 2) begin
                dmas++;
                pg = 8'($urandom);
                for (int i = 0; i < 256; i++) begin
                    a = {pg, 8'(i)};
                    exp_txn.push_back('{a, 1'b0, 8'h00});
                    exp_txn.push_back('{16'h2004, 1'b1, ref_mem[a]});
                    ref_mem[16'h2004] = ref_mem[a];
                end
                strobe(16'h4014, pg, 1'b1);
            end else if (n < 60) begin
                a = (n % 5 == 0) ? 16'h2004 : 16'($urandom);
                exp_txn.push_back('{a, 1'b0, 8'h00});
                exp_resp.push_back(ref_mem[a]);
                strobe(a, 8'h00, 1'b0);
            end else begin
                a = 16'($urandom);
                if (a == 16'h4014) a = 16'h4015;
                d = 8'($urandom);
                exp_txn.push_back('{a, 1'b1, d});
                ref_mem[a] = d;
                strobe(a, d, 1'b1);
            end
            n = 0;
            while (!(log1.size() == exp_txn.size() && resp1.size() == exp_resp.size()
                     && !cpu_stall_o) && n < 5000) begin
                n++;
                @(negedge clock_i);
            end
            chk($sformatf("rand%0d_done", op), {31'b0, n < 5000}, 1);
            while (tcmp < log1.size() && tcmp < exp_txn.size()) begin
                if (exp_txn[tcmp].wr)
                    chk($sformatf("rand%0d_txn%0d", op, tcmp),
                        {log1[tcmp].addr, log1[tcmp].wr, log1[tcmp].data},
                        {exp_txn[tcmp].addr, 1'b1, exp_txn[tcmp].data});
                else
                    chk($sformatf("rand%0d_txn%0d", op, tcmp),
                        {log1[tcmp].addr, log1[tcmp].wr},
                        {exp_txn[tcmp].addr, 1'b0});
                tcmp++;
            end
            while (rcmp < resp1.size() && rcmp < exp_resp.size()) begin
                chk($sformatf("rand%0d_resp%0d", op, rcmp), resp1[rcmp], exp_resp[rcmp]);
                rcmp++;
            end
            repeat ($urandom_range(0, 3)) @(negedge clock_i);
        end
        repeat (4) @(negedge clock_i);
        chk("rand_txn_total", log1.size(), exp_txn.size());
        chk("rand_resp_total", resp1.size(), exp_resp.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
